instr_decode: RTL and testbench

- IF/ID decode stage directly upstream of the register file.
- Accepts 16-bit instruction words from fetch and decodes them into register-file read/write addresses and control bits, registered once per cycle.
- Detects load-use hazards and inserts one bubble while stalling fetch.
- Handles the two-word LDM instruction (opcode word, then immediate word) with a small FSM.
- Outputs update on posedge clk, so the register file samples stable addresses on the following negedge.

---
 rtl/isa_pkg.sv | 96 +++++++++
 rtl/instr_decode_if.sv | 40 ++++
 rtl/hazard_detect.sv | 24 ++
 rtl/instr_decode.sv | 113 +++++++++++
 tb/tb_instr_decode.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | isa_pkg: ISA field layout, opcodes, decoder state and decode helpers  |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
package isa_pkg;

   localparam int DATA_W = 16;
   localparam int REG_AW = 3;
   localparam int OPC_W  = 5;

   localparam int OPC_MSB  = 15;
   localparam int OPC_LSB  = 11;
   localparam int RDST_MSB = 10;
   localparam int RDST_LSB = 8;
   localparam int RS1_MSB  = 7;
   localparam int RS1_LSB  = 5;
   localparam int RS2_MSB  = 4;
   localparam int RS2_LSB  = 2;

   localparam logic [OPC_W-1:0] OP_NOP = 5'b00000;
   localparam logic [OPC_W-1:0] OP_NOT = 5'b00001;
   localparam logic [OPC_W-1:0] OP_INC = 5'b00010;
   localparam logic [OPC_W-1:0] OP_DEC = 5'b00011;
   localparam logic [OPC_W-1:0] OP_MOV = 5'b00100;
   localparam logic [OPC_W-1:0] OP_ADD = 5'b01000;
   localparam logic [OPC_W-1:0] OP_SUB = 5'b01001;
   localparam logic [OPC_W-1:0] OP_AND = 5'b01010;
   localparam logic [OPC_W-1:0] OP_OR  = 5'b01011;
   localparam logic [OPC_W-1:0] OP_LDM = 5'b10000;
   localparam logic [OPC_W-1:0] OP_LDD = 5'b10001;
   localparam logic [OPC_W-1:0] OP_STD = 5'b10010;

   localparam logic [1:0] ST_DECODE = 2'd0;
   localparam logic [1:0] ST_IMM    = 2'd1;
   localparam logic [1:0] ST_STALL  = 2'd2;

   typedef struct packed {
      logic [REG_AW-1:0] read_addr1;
      logic [REG_AW-1:0] read_addr2;
      logic [REG_AW-1:0] write_addr;
      logic              one_operand;
      logic              mem_read;
      logic              mem_write;
      logic              reg_write;
      logic [OPC_W-1:0]  alu_op;
      logic [DATA_W-1:0] imm;
      logic              imm_valid;
      logic              dec_valid;
   } dec_out_t;

   localparam dec_out_t BUBBLE = '0;

   function automatic logic uses_rs1(input logic [OPC_W-1:0] op);
      case (op)
         OP_NOT, OP_INC, OP_DEC, OP_MOV,
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_LDD, OP_STD: return 1'b1;
         default:        return 1'b0;
      endcase
   endfunction

   function automatic logic uses_rs2(input logic [OPC_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_STD: return 1'b1;
         default:                               return 1'b0;
      endcase
   endfunction

   function automatic logic is_legal(input logic [OPC_W-1:0] op);
      return (op == OP_NOP) || (op == OP_LDM) || uses_rs1(op);
   endfunction

   // Single-word decode; NOP, LDM and illegal opcodes all yield a bubble.
   function automatic dec_out_t decode_word(input logic [DATA_W-1:0] instr);
      dec_out_t         d;
      logic [OPC_W-1:0] op;
      op = instr[OPC_MSB:OPC_LSB];
      d  = BUBBLE;
      if (uses_rs1(op)) begin
         d.dec_valid   = 1'b1;
         d.alu_op      = op;
         d.read_addr1  = instr[RS1_MSB:RS1_LSB];
         d.read_addr2  = uses_rs2(op) ? instr[RS2_MSB:RS2_LSB] : '0;
         d.one_operand = (op == OP_NOT) || (op == OP_INC) ||
                         (op == OP_DEC) || (op == OP_MOV);
         d.mem_read    = (op == OP_LDD);
         d.mem_write   = (op == OP_STD);
         d.reg_write   = (op != OP_STD);
         d.write_addr  = (op != OP_STD) ? instr[RDST_MSB:RDST_LSB] : '0;
      end
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decode_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_decode_if: fetch -> decode -> register-file signal bundle       |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
interface instr_decode_if;
   import isa_pkg::*;

   logic [DATA_W-1:0] instr_in;
   logic              instr_valid;
   logic              flush;
   logic              pc_en;
   logic [REG_AW-1:0] read_addr1;
   logic [REG_AW-1:0] read_addr2;
   logic [REG_AW-1:0] write_addr;
   logic              one_operand;
   logic              mem_read;
   logic              mem_write;
   logic              reg_write;
   logic [OPC_W-1:0]  alu_op;
   logic [DATA_W-1:0] imm;
   logic              imm_valid;
   logic              dec_valid;
   logic              illegal_op;

   modport master (
      output instr_in, instr_valid, flush,
      input  pc_en, read_addr1, read_addr2, write_addr, one_operand,
             mem_read, mem_write, reg_write, alu_op, imm, imm_valid,
             dec_valid, illegal_op
   );

   modport slave (
      input  instr_in, instr_valid, flush,
      output pc_en, read_addr1, read_addr2, write_addr, one_operand,
             mem_read, mem_write, reg_write, alu_op, imm, imm_valid,
             dec_valid, illegal_op
   );
endinterface
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_detect: load-use hazard between the decoded load and new word  |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module hazard_detect
   import isa_pkg::*;
(
   input  logic              i_prev_mem_read,
   input  logic              i_prev_dec_valid,
   input  logic [REG_AW-1:0] i_prev_write_addr,
   input  logic [OPC_W-1:0]  i_opcode,
   input  logic [REG_AW-1:0] i_rsrc1,
   input  logic [REG_AW-1:0] i_rsrc2,
   output logic              o_hazard
);
   logic w_match1;
   logic w_match2;

   assign w_match1 = uses_rs1(i_opcode) && (i_rsrc1 == i_prev_write_addr);
   assign w_match2 = uses_rs2(i_opcode) && (i_rsrc2 == i_prev_write_addr);
   assign o_hazard = i_prev_mem_read && i_prev_dec_valid && (w_match1 || w_match2);
endmodule
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_decode: IF/ID stage with load-use stall and two-word LDM        |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module instr_decode
   import isa_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   instr_decode_if.slave bus
);
   logic [1:0]        r_state;
   logic [REG_AW-1:0] r_ldm_rdst;
   dec_out_t          r_out;
   logic              r_illegal;

   logic [1:0]        w_next_state;
   logic [REG_AW-1:0] w_next_rdst;
   dec_out_t          w_next_out;
   logic              w_next_illegal;
   logic              w_stall_req;
   logic              w_hazard;
   logic [OPC_W-1:0]  w_opcode;

   assign w_opcode = bus.instr_in[OPC_MSB:OPC_LSB];

   hazard_detect u_hazard (
      .i_prev_mem_read  (r_out.mem_read),
      .i_prev_dec_valid (r_out.dec_valid),
      .i_prev_write_addr(r_out.write_addr),
      .i_opcode         (w_opcode),
      .i_rsrc1          (bus.instr_in[RS1_MSB:RS1_LSB]),
      .i_rsrc2          (bus.instr_in[RS2_MSB:RS2_LSB]),
      .o_hazard         (w_hazard)
   );

   always_comb begin
      w_next_state   = r_state;
      w_next_rdst    = r_ldm_rdst;
      w_next_out     = BUBBLE;
      w_next_illegal = 1'b0;
      w_stall_req    = 1'b0;
      if (bus.flush) begin
         w_next_state = ST_DECODE;
         w_next_rdst  = '0;
      end else begin
         case (r_state)
            ST_DECODE: begin
               if (bus.instr_valid) begin
                  if (w_hazard) begin
                     w_stall_req  = 1'b1;
                     w_next_state = ST_STALL;
                  end else if (w_opcode == OP_LDM) begin
                     w_next_rdst  = bus.instr_in[RDST_MSB:RDST_LSB];
                     w_next_state = ST_IMM;
                  end else if (!is_legal(w_opcode)) begin
                     w_next_illegal = 1'b1;
                  end else begin
                     w_next_out = decode_word(bus.instr_in);
                  end
               end
            end
            // Fetch has held the word, so it is decoded without re-checking.
            ST_STALL: begin
               w_next_out   = decode_word(bus.instr_in);
               w_next_state = ST_DECODE;
            end
            ST_IMM: begin
               if (bus.instr_valid) begin
                  w_next_out.reg_write  = 1'b1;
                  w_next_out.write_addr = r_ldm_rdst;
                  w_next_out.imm        = bus.instr_in;
                  w_next_out.imm_valid  = 1'b1;
                  w_next_out.alu_op     = OP_LDM;
                  w_next_out.dec_valid  = 1'b1;
                  w_next_state          = ST_DECODE;
               end
            end
            default: w_next_state = ST_DECODE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_DECODE;
         r_ldm_rdst <= '0;
         r_out      <= BUBBLE;
         r_illegal  <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_ldm_rdst <= w_next_rdst;
         r_out      <= w_next_out;
         r_illegal  <= w_next_illegal;
      end
   end

   assign bus.pc_en       = reset || !w_stall_req;
   assign bus.read_addr1  = r_out.read_addr1;
   assign bus.read_addr2  = r_out.read_addr2;
   assign bus.write_addr  = r_out.write_addr;
   assign bus.one_operand = r_out.one_operand;
   assign bus.mem_read    = r_out.mem_read;
   assign bus.mem_write   = r_out.mem_write;
   assign bus.reg_write   = r_out.reg_write;
   assign bus.alu_op      = r_out.alu_op;
   assign bus.imm         = r_out.imm;
   assign bus.imm_valid   = r_out.imm_valid;
   assign bus.dec_valid   = r_out.dec_valid;
   assign bus.illegal_op  = r_illegal;
endmodule
`default_nettype wire

// File: tb/tb_instr_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_decode: directed checks of decode, stall, LDM, flush, reset  |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module tb_instr_decode;
   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;

   instr_decode_if bus ();

   instr_decode dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {ra1, ra2, wa, one_op, mem_rd, mem_wr, reg_wr, alu_op, imm, imm_valid, dec_valid}
   function automatic logic [35:0] obs();
      return {bus.read_addr1, bus.read_addr2, bus.write_addr, bus.one_operand,
              bus.mem_read, bus.mem_write, bus.reg_write, bus.alu_op,
              bus.imm, bus.imm_valid, bus.dec_valid};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.instr_in = 16'h0000;
      bus.instr_valid = 1'b0;
      bus.flush = 1'b0;
      tick();
      tick();
      tests_run++;
      if (obs() !== 36'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs got=%h want=%h", obs(), 36'h0);
      end
      tests_run++;
      if ({bus.pc_en, bus.illegal_op} !== 2'b10) begin
         tests_failed++;
         $display("FAIL reset_pc_en_illegal got=%b want=10", {bus.pc_en, bus.illegal_op});
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_add();
      logic [35:0] exp;
      exp = {3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 5'b01000, 16'h0000, 1'b0, 1'b1};
      bus.instr_in = 16'h4328;
      bus.instr_valid = 1'b1;
      #1;
      tests_run++;
      if (bus.pc_en !== 1'b1) begin
         tests_failed++;
         $display("FAIL add_pc_en_pre got=%b want=1", bus.pc_en);
      end
      tick();
      tests_run++;
      if (obs() !== exp) begin
         tests_failed++;
         $display("FAIL add_decode got=%h want=%h", obs(), exp);
      end
      bus.instr_valid = 1'b0;
      tick();
      tests_run++;
      if (obs() !== 36'h0) begin
         tests_failed++;
         $display("FAIL add_idle_bubble got=%h want=%h", obs(), 36'h0);
      end
   endtask

   task automatic test_async_reset();
      bus.instr_in = 16'h4328;
      bus.instr_valid = 1'b1;
      tick();
      tests_run++;
      if (bus.dec_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL async_pre_valid got=%b want=1", bus.dec_valid);
      end
      bus.instr_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      tests_run++;
      if (obs() !== 36'h0) begin
         tests_failed++;
         $display("FAIL async_reset_clear got=%h want=%h", obs(), 36'h0);
      end
      #1 reset = 1'b0;
      tick();
   endtask

   task automatic test_load_use();
      logic [35:0] exp_ldd;
      logic [35:0] exp_add;
      exp_ldd = {3'd1, 3'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 5'b10001, 16'h0000, 1'b0, 1'b1};
      exp_add = {3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 5'b01000, 16'h0000, 1'b0, 1'b1};
      bus.instr_in = 16'h8A20;
      bus.instr_valid = 1'b1;
      tick();
      tests_run++;
      if (obs() !== exp_ldd) begin
         tests_failed++;
         $display("FAIL ldd_decode got=%h want=%h", obs(), exp_ldd);
      end
      bus.instr_in = 16'h4328;
      #1;
      tests_run++;
      if (bus.pc_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL load_use_pc_en got=%b want=0", bus.pc_en);
      end
      tick();
      tests_run++;
      if (obs() !== 36'h0) begin
         tests_failed++;
         $display("FAIL load_use_bubble got=%h want=%h", obs(), 36'h0);
      end
      tests_run++;
      if (bus.pc_en !== 1'b1) begin
         tests_failed++;
         $display("FAIL stall_pc_en got=%b want=1", bus.pc_en);
      end
      tick();
      tests_run++;
      if (obs() !== exp_add) begin
         tests_failed++;
         $display("FAIL load_use_add got=%h want=%h", obs(), exp_add);
      end
      bus.instr_valid = 1'b0;
      tick();
   endtask

   task automatic test_ldm();
      logic [35:0] exp;
      exp = {3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 5'b10000, 16'h1234, 1'b1, 1'b1};
      bus.instr_in = 16'h8500;
      bus.instr_valid = 1'b1;
      tick();
      tests_run++;
      if (obs() !== 36'h0) begin
         tests_failed++;
         $display("FAIL ldm_first_bubble got=%h want=%h", obs(), 36'h0);
      end
      bus.instr_valid = 1'b0;
      tick();
      tests_run++;
      if (obs() !== 36'h0) begin
         tests_failed++;
         $display("FAIL ldm_idle_bubble got=%h want=%h", obs(), 36'h0);
      end
      bus.instr_in = 16'h1234;
      bus.instr_valid = 1'b1;
      tick();
      tests_run++;
      if (obs() !== exp) begin
         tests_failed++;
         $display("FAIL ldm_imm got=%h want=%h", obs(), exp);
      end
      bus.instr_valid = 1'b0;
      tick();
      tests_run++;
      if (obs() !== 36'h0) begin
         tests_failed++;
         $display("FAIL ldm_after_bubble got=%h want=%h", obs(), 36'h0);
      end
   endtask

   task automatic test_std_illegal();
      logic [35:0] exp;
      exp = {3'd4, 3'd5, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10010, 16'h0000, 1'b0, 1'b1};
      bus.instr_in = 16'h9094;
      bus.instr_valid = 1'b1;
      tick();
      tests_run++;
      if (obs() !== exp) begin
         tests_failed++;
         $display("FAIL std_decode got=%h want=%h", obs(), exp);
      end
      bus.instr_in = 16'hF800;
      tick();
      tests_run++;
      if ({bus.illegal_op, obs()} !== {1'b1, 36'h0}) begin
         tests_failed++;
         $display("FAIL illegal_pulse got=%h want=%h", {bus.illegal_op, obs()}, {1'b1, 36'h0});
      end
      bus.instr_valid = 1'b0;
      tick();
      tests_run++;
      if (bus.illegal_op !== 1'b0) begin
         tests_failed++;
         $display("FAIL illegal_one_cycle got=%b want=0", bus.illegal_op);
      end
   endtask

   task automatic test_flush();
      logic [35:0] exp;
      exp = {3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 5'b01000, 16'h0000, 1'b0, 1'b1};
      bus.instr_in = 16'hF800;
      bus.instr_valid = 1'b1;
      bus.flush = 1'b1;
      tick();
      tests_run++;
      if (bus.illegal_op !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_illegal_suppressed got=%b want=0", bus.illegal_op);
      end
      bus.flush = 1'b0;
      bus.instr_in = 16'h8500;
      tick();
      bus.instr_in = 16'h1234;
      bus.flush = 1'b1;
      #1;
      tests_run++;
      if (bus.pc_en !== 1'b1) begin
         tests_failed++;
         $display("FAIL flush_pc_en got=%b want=1", bus.pc_en);
      end
      tick();
      tests_run++;
      if (obs() !== 36'h0) begin
         tests_failed++;
         $display("FAIL flush_bubble got=%h want=%h", obs(), 36'h0);
      end
      bus.flush = 1'b0;
      bus.instr_in = 16'h4328;
      tick();
      tests_run++;
      if (obs() !== exp) begin
         tests_failed++;
         $display("FAIL flush_then_add got=%h want=%h", obs(), exp);
      end
      bus.instr_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_ldm();
      logic [35:0] exp;
      exp = {3'd1, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00010, 16'h0000, 1'b0, 1'b1};
      bus.instr_in = 16'h8500;
      bus.instr_valid = 1'b1;
      tick();
      bus.instr_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      tests_run++;
      if (obs() !== 36'h0) begin
         tests_failed++;
         $display("FAIL mid_ldm_reset_bubble got=%h want=%h", obs(), 36'h0);
      end
      #1 reset = 1'b0;
      bus.instr_in = 16'h1234;
      bus.instr_valid = 1'b1;
      tick();
      tests_run++;
      if (obs() !== exp) begin
         tests_failed++;
         $display("FAIL mid_ldm_inc got=%h want=%h", obs(), exp);
      end
      bus.instr_valid = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired tests_run=%0d", tests_run);
      $fatal(1, "timeout");
   end

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_add();
      test_async_reset();
      test_load_use();
      test_ldm();
      test_std_illegal();
      test_flush();
      test_reset_mid_ldm();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
`default_nettype wire
